// File: rtl/sys_array_engine.sv
// Output-stationary systolic matrix-multiply engine: streams k-slices of A (columns)
// and B (rows) through a ROWS x COLS PE grid, then drains C one row at a time.
module sys_array_engine #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 32,
    parameter int KW   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ROWS*DW-1:0]        a_data,
    input  logic [COLS*DW-1:0]        b_data,
    output logic                      busy,
    output logic                      done,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [COLS*AW-1:0]        res_data,
    output logic [$clog2(ROWS)-1:0]   res_row,
    output logic                      res_last
);

    localparam int RW         = $clog2(ROWS);
    localparam int FW         = $clog2(ROWS + COLS) + 1;
    localparam int FLUSH_LAST = ROWS + COLS - 2;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t              state_q;
    logic [KW-1:0]       k_len_q;
    logic [KW-1:0]       k_cnt_q;
    logic [FW-1:0]       flush_cnt_q;
    logic [RW-1:0]       res_row_q;
    logic [RW-1:0]       res_row_d;
    logic                a_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                res_valid_q;
    logic                res_last_q;
    logic [COLS*AW-1:0]  res_data_q;
    logic [COLS*AW-1:0]  row_mux;

    logic clr;
    logic inj;

    logic signed [DW-1:0] a_edge [ROWS];
    logic signed [DW-1:0] b_edge [COLS];
    logic signed [DW-1:0] a_hop  [ROWS][COLS-1];
    logic signed [DW-1:0] b_hop  [ROWS-1][COLS];
    logic [AW-1:0]        acc    [ROWS][COLS];

    // An accepted start wipes the whole datapath so stale skew contents never leak into a new job.
    assign clr = (state_q == IDLE) && start && (k_len != '0);
    // Bubbles and non-LOAD cycles feed zeros, so their products add nothing.
    assign inj = a_ready_q && a_valid;

    genvar gi, gj;

    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
        logic signed [DW-1:0] a_in;
        assign a_in = inj ? $signed(a_data[gi*DW +: DW]) : '0;
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_in;
        end else begin : g_delay
            logic signed [DW-1:0] sr_q [gi];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < gi; i++) sr_q[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < gi; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= a_in;
                    for (int i = 1; i < gi; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign a_edge[gi] = sr_q[gi-1];
        end
    end

    for (gi = 0; gi < COLS; gi++) begin : g_b_skew
        logic signed [DW-1:0] b_in;
        assign b_in = inj ? $signed(b_data[gi*DW +: DW]) : '0;
        if (gi == 0) begin : g_direct
            assign b_edge[gi] = b_in;
        end else begin : g_delay
            logic signed [DW-1:0] sr_q [gi];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < gi; i++) sr_q[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < gi; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= b_in;
                    for (int i = 1; i < gi; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign b_edge[gi] = sr_q[gi-1];
        end
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_pe
            logic signed [DW-1:0]   a_w;
            logic signed [DW-1:0]   b_w;
            logic signed [2*DW-1:0] prod;
            logic [AW-1:0]          acc_q;

            if (gj == 0) begin : g_a_edge
                assign a_w = a_edge[gi];
            end else begin : g_a_left
                assign a_w = a_hop[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_w = b_edge[gj];
            end else begin : g_b_up
                assign b_w = b_hop[gi-1][gj];
            end

            assign prod = a_w * b_w;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q <= '0;
                end else if (clr) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_q + AW'(prod);
                end
            end
            assign acc[gi][gj] = acc_q;

            // Edge PEs have no neighbour to forward to, so they skip the pass-through register.
            if (gj < COLS - 1) begin : g_fwd_a
                logic signed [DW-1:0] a_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)      a_q <= '0;
                    else if (clr) a_q <= '0;
                    else          a_q <= a_w;
                end
                assign a_hop[gi][gj] = a_q;
            end
            if (gi < ROWS - 1) begin : g_fwd_b
                logic signed [DW-1:0] b_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)      b_q <= '0;
                    else if (clr) b_q <= '0;
                    else          b_q <= b_w;
                end
                assign b_hop[gi][gj] = b_q;
            end
        end
    end

    always_comb begin
        res_row_d = (state_q == DRAIN) ? res_row_q + RW'(1) : '0;
        row_mux   = '0;
        for (int c = 0; c < COLS; c++) row_mux[c*AW +: AW] = acc[res_row_d][c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            flush_cnt_q <= '0;
            res_row_q   <= '0;
            a_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && (k_len != '0)) begin
                        k_len_q   <= k_len;
                        k_cnt_q   <= '0;
                        a_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    if (a_valid) begin
                        k_cnt_q <= k_cnt_q + KW'(1);
                        if (k_cnt_q == k_len_q - KW'(1)) begin
                            a_ready_q   <= 1'b0;
                            flush_cnt_q <= '0;
                            state_q     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + FW'(1);
                    if (flush_cnt_q == FW'(FLUSH_LAST)) begin
                        res_valid_q <= 1'b1;
                        res_row_q   <= '0;
                        res_last_q  <= 1'b0;
                        res_data_q  <= row_mux;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (res_row_q == RW'(ROWS - 1)) begin
                            res_valid_q <= 1'b0;
                            res_last_q  <= 1'b0;
                            res_row_q   <= '0;
                            res_data_q  <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            res_row_q  <= res_row_d;
                            res_last_q <= (res_row_d == RW'(ROWS - 1));
                            res_data_q <= row_mux;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_ready   = a_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign res_last  = res_last_q;
    assign res_row   = res_row_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_sys_array_engine.sv
// Bench for sys_array_engine: jobs with random data, bubbles and backpressure are
// checked against a plain matrix-product model plus latency and handshake rules.
module tb_sys_array_engine;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int KW   = 8;
    localparam int MAXK = 255;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [KW-1:0]           k_len;
    logic                    a_valid;
    logic                    a_ready;
    logic [ROWS*DW-1:0]      a_data;
    logic [COLS*DW-1:0]      b_data;
    logic                    busy;
    logic                    done;
    logic                    res_valid;
    logic                    res_ready;
    logic [COLS*AW-1:0]      res_data;
    logic [$clog2(ROWS)-1:0] res_row;
    logic                    res_last;

    sys_array_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .b_data    (b_data),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_row   (res_row),
        .res_last  (res_last)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    int mat_a [ROWS][MAXK];
    int mat_b [MAXK][COLS];
    int exp_c [ROWS][COLS];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_identity();
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < ROWS; r++) mat_a[r][s] = (r == s) ? 1 : 0;
            for (int c = 0; c < COLS; c++) mat_b[s][c] = 10 * s + c;
        end
    endtask

    task automatic fill_random(input int k);
        for (int s = 0; s < k; s++) begin
            for (int r = 0; r < ROWS; r++) mat_a[r][s] = int'($urandom_range(255)) - 128;
            for (int c = 0; c < COLS; c++) mat_b[s][c] = int'($urandom_range(255)) - 128;
        end
    endtask

    task automatic fill_const(input int k, input int v);
        for (int s = 0; s < k; s++) begin
            for (int r = 0; r < ROWS; r++) mat_a[r][s] = v;
            for (int c = 0; c < COLS; c++) mat_b[s][c] = v;
        end
    endtask

    // C = A * B over k slices; int arithmetic wraps modulo 2^32, matching AW.
    task automatic compute_model(input int k);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int sum;
                sum = 0;
                for (int s = 0; s < k; s++) sum += mat_a[r][s] * mat_b[s][c];
                exp_c[r][c] = sum;
            end
        end
    endtask

    task automatic drive_slice(input int s);
        for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = mat_a[r][s][DW-1:0];
        for (int c = 0; c < COLS; c++) b_data[c*DW +: DW] = mat_b[s][c][DW-1:0];
    endtask

    // ready_mode: 0 = always ready, 1 = hold row 1 for 3 cycles, 2 = random
    task automatic run_job(input int k, input int bubble_pct, input int ready_mode,
                           input bit start_in_load);
        int cyc, s, bubbles, guard, r, hold, done0;
        bit v, rdy;
        compute_model(k);
        done0 = done_cnt;
        @(negedge clk);
        check("idle_busy", busy, 0);
        start   = 1'b1;
        k_len   = k[KW-1:0];
        a_valid = 1'b1;
        a_data  = $urandom;
        b_data  = $urandom;
        @(negedge clk);
        cyc = 1; s = 0; bubbles = 0; guard = 0;
        while (s < k && guard < 2000) begin
            check("a_ready_load", a_ready, 1);
            start = 1'b0;
            if (start_in_load && s == 1) begin
                start = 1'b1;
                k_len = 1;
            end
            v = ($urandom_range(99) >= bubble_pct);
            a_valid = v;
            if (v) drive_slice(s);
            else begin
                a_data = $urandom;
                b_data = $urandom;
            end
            @(negedge clk);
            cyc++; guard++;
            if (v) s++;
            else bubbles++;
        end
        check("load_guard", guard < 2000, 1);
        start   = 1'b0;
        a_valid = 1'b0;
        check("a_ready_flush", a_ready, 0);
        check("busy_flush", busy, 1);
        guard = 0;
        while (!res_valid && guard < 200) begin
            @(negedge clk);
            cyc++; guard++;
        end
        check("res_valid_timeout", res_valid, 1);
        check("latency", cyc, 1 + k + bubbles + ROWS + COLS - 1);
        r = 0; hold = 0; guard = 0;
        while (r < ROWS && guard < 500) begin
            check("res_valid", res_valid, 1);
            check("res_row", res_row, r);
            check("res_last", res_last, (r == ROWS - 1));
            for (int c = 0; c < COLS; c++)
                check("res_data", res_data[c*AW +: AW], exp_c[r][c][AW-1:0]);
            check("busy_drain", busy, 1);
            if (ready_mode == 1)      rdy = !(r == 1 && hold < 3);
            else if (ready_mode == 2) rdy = ($urandom_range(1) == 1);
            else                      rdy = 1'b1;
            res_ready = rdy;
            @(negedge clk);
            guard++;
            if (rdy) r++;
            else hold++;
        end
        res_ready = 1'b0;
        check("drain_guard", guard < 500, 1);
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        check("res_valid_after", res_valid, 0);
        check("res_last_after", res_last, 0);
        @(negedge clk);
        check("done_single", done, 0);
        check("done_count", done_cnt - done0, 1);
        $display("[TB] job k=%0d bubbles=%0d latency=%0d ready_mode=%0d holds=%0d",
                 k, bubbles, cyc, ready_mode, hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_ready"}, a_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_last"}, res_last, 0);
        check({tag, "_res_row"}, res_row, 0);
        check({tag, "_res_data"}, res_data[63:0], 0);
        check({tag, "_res_data_hi"}, res_data[COLS*AW-1:64], 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done0;
        rst = 1'b1; start = 1'b0; k_len = '0; a_valid = 1'b0;
        a_data = '0; b_data = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Identity, no bubbles
        fill_identity();
        run_job(4, 0, 0, 0);

        // Same data with bubbles
        fill_identity();
        run_job(4, 40, 0, 0);

        // Row 1 backpressure with random data
        fill_random(6);
        run_job(6, 0, 1, 0);

        // Signed extreme: every element -128, k=255
        fill_const(MAXK, -128);
        run_job(MAXK, 0, 0, 0);

        // start with k_len=0 must be ignored
        done0 = done_cnt;
        @(negedge clk);
        start = 1'b1; k_len = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            check("zero_k_busy", busy, 0);
            check("zero_k_a_ready", a_ready, 0);
            @(negedge clk);
        end
        check("zero_k_done", done_cnt - done0, 0);

        // start during LOAD must not disturb the job
        fill_random(5);
        run_job(5, 20, 0, 1);

        // Reset in the middle of LOAD after two slices
        fill_identity();
        @(negedge clk);
        start = 1'b1; k_len = 4;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            a_valid = 1'b1;
            drive_slice(s);
            @(negedge clk);
        end
        rst = 1'b1;
        a_valid = 1'b0;
        #1;
        check_reset_outputs("mid_load_rst");
        @(negedge clk);
        check_reset_outputs("mid_load_rst_held");
        rst = 1'b0;
        fill_identity();
        run_job(4, 0, 0, 0);

        // Random jobs with bubbles and random consumer readiness
        repeat (4) begin
            int k;
            k = $urandom_range(1, 20);
            fill_random(k);
            run_job(k, 30, 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_array_engine.md
SYS_ARRAY_ENGINE -- requirements
Module: sys_array_engine

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, number of PE rows (>=2).
REQ-002 The block SHALL have parameter COLS, default 4, number of PE columns (>=2).
REQ-003 The block SHALL have parameter DW, default 8, signed operand width.
REQ-004 The block SHALL have parameter AW, default 32, signed accumulator width.
REQ-005 The block SHALL have parameter KW, default 8, width of k_len.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1, job request, sampled in IDLE only.
REQ-009 The block SHALL have port k_len, input, KW, number of k-slices (accumulation depth), sampled with start.
REQ-010 The block SHALL have port a_valid, input, 1, a_data/b_data carry one k-slice.
REQ-011 The block SHALL have port a_ready, output, 1, block accepts a k-slice.
REQ-012 The block SHALL have port a_data, input, ROWS*DW, A column slice; row r at [r*DW +: DW].
REQ-013 The block SHALL have port b_data, input, COLS*DW, B row slice; column c at [c*DW +: DW].
REQ-014 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse at job completion.
REQ-016 The block SHALL have port res_valid, output, 1, res_data holds one result row.
REQ-017 The block SHALL have port res_ready, input, 1, consumer accepts the row.
REQ-018 The block SHALL have port res_data, output, COLS*AW, C[res_row][c] at [c*AW +: AW].
REQ-019 The block SHALL have port res_row, output, $clog2(ROWS), index of the presented row.
REQ-020 The block SHALL have port res_last, output, 1, high with res_valid on row ROWS-1.

Function
REQ-021 The block SHALL implement an output-stationary ROWS x COLS grid; PE(r,c) registers a rightward and b downward each cycle and adds sign-extended a*b to its AW-bit accumulator, wrapping modulo 2^AW.
REQ-022 The block SHALL delay input row r of A by r cycles and column c of B by c cycles (skew registers) before the grid edge.
REQ-023 The FSM SHALL have states IDLE, LOAD, FLUSH and DRAIN.
REQ-024 In IDLE, start=1 with k_len!=0 SHALL latch k_len, clear all accumulators, skew and pipeline registers, and enter LOAD next cycle; start with k_len==0 SHALL be ignored.
REQ-025 In LOAD, a_ready SHALL be 1; each cycle with a_valid=1 SHALL inject one slice; each cycle with a_valid=0 SHALL inject zeros on all edges (bubble) and not count.
REQ-026 After the k_len-th accepted slice, the FSM SHALL enter FLUSH; a_ready SHALL be 0 outside LOAD.
REQ-027 FLUSH SHALL inject zeros for exactly ROWS+COLS-1 cycles, then enter DRAIN.
REQ-028 In DRAIN, the block SHALL present rows 0..ROWS-1 in order with res_valid=1, advancing on res_valid&&res_ready; res_data/res_row SHALL be stable while res_ready=0.
REQ-029 On the handshake of row ROWS-1, the block SHALL return to IDLE and pulse done=1 for the following single cycle.
REQ-030 start while busy=1 SHALL be ignored; accumulators SHALL hold until the next accepted start.
REQ-031 Results SHALL be bit-identical regardless of bubble placement.

Reset
REQ-032 rst=1 SHALL force IDLE and clear all accumulators, skew/pipeline registers and counters asynchronously, including mid-job.
REQ-033 During and after reset: a_ready=0, busy=0, done=0, res_valid=0, res_last=0, res_row=0, res_data=0.

Verification
REQ-034 Identity: ROWS=COLS=4, k_len=4, A=I, B[k][c]=10k+c, no bubbles -> rows equal B, done once; total latency start->first res_valid = 1+4+7 cycles.
REQ-035 Signed extreme: k_len=255, all a=b=-128 -> every res_data element = 4177920.
REQ-036 Bubbles: repeat REQ-034 data with random a_valid=0 gaps -> identical results; busy extended by gap count.
REQ-037 Backpressure: res_ready=0 for 3 cycles on row 1 -> row 1 data stable, order 0,1,2,3, res_last only on row 3, done one cycle after final handshake.
REQ-038 Ignored starts: start with k_len=0 -> busy stays 0, no done; start during LOAD -> no effect on results.
REQ-039 Reset mid-LOAD after 2 slices -> all outputs at reset values next cycle; subsequent REQ-034 job correct.
